// File: rtl/ram_arbiter.sv
// ram_arbiter: shares the byte-wide RAM/IO port between instruction fetch and
// the data stage. Each 1/2/4-byte request becomes a series of per-byte RAM
// cycles, and read bytes are assembled little-endian into a 32-bit word.
// Optional feature macro: IO_FULL_WAIT_EN. When it is defined, IO-space stores
// wait while the uart tx buffer is full. When it is undefined,
// io_buffer_full is ignored.
module ram_arbiter #(
  parameter int         ADDR_W = 32,
  parameter logic [1:0] IO_HI  = 2'b11
) (
  input  logic              clk_in,
  input  logic              rst_in,
  input  logic              rdy_in,
  input  logic              io_buffer_full,
  input  logic [7:0]        ram_din,
  output logic [7:0]        ram_dout,
  output logic [ADDR_W-1:0] ram_a,
  output logic              ram_wr,
  input  logic              if_pc_get,
  input  logic [ADDR_W-1:0] if_pc_address,
  input  logic              if_flush,
  output logic              if_done,
  output logic [31:0]       if_out,
  input  logic              mem_get,
  input  logic              mem_wr,
  input  logic [ADDR_W-1:0] mem_address,
  input  logic [31:0]       mem_data,
  input  logic [2:0]        mem_len,
  output logic              mem_done,
  output logic [31:0]       mem_out
);

  typedef enum logic [1:0] {IDLE, IF_RD, MEM_RD, MEM_WR} state_t;

  state_t              state_reg;
  logic [ADDR_W-1:0]   addr_reg;
  logic [31:0]         data_reg;
  logic [2:0]          len_reg;
  logic [2:0]          iss_reg;     // bytes addressed so far
  logic [2:0]          cap_reg;     // bytes captured (read) / committed (write)
  logic                pipe1_reg;   // a read address was issued one edge ago
  logic                pipe2_reg;   // a read address was issued two edges ago
  logic                paused_reg;  // rdy_in was low at the previous edge
  logic [31:0]         asm_reg;     // read bytes assembled so far
  logic [ADDR_W-1:0]   ram_a_reg;
  logic [7:0]          ram_dout_reg;
  logic                ram_wr_reg;
  logic                if_done_reg;
  logic [31:0]         if_out_reg;
  logic                mem_done_reg;
  logic [31:0]         mem_out_reg;

  logic [2:0]          len_dec;
  logic [ADDR_W-1:0]   iss_addr;
  logic [ADDR_W-1:0]   cap_addr;
  logic [31:0]         wr_shift;
  logic [7:0]          wr_byte;
  logic [2:0]          rd_cap_next;
  logic [2:0]          wr_cap_next;
  logic [31:0]         asm_next;
  logic                io_block;

  // Decode the requested length; anything other than 1 or 2 is a word access.
  always_comb begin
    len_dec = 3'd4;
    case (mem_len)
      3'd1:    len_dec = 3'd1;
      3'd2:    len_dec = 3'd2;
      default: len_dec = 3'd4;
    endcase
  end

  assign iss_addr    = addr_reg + ADDR_W'(iss_reg);
  assign cap_addr    = addr_reg + ADDR_W'(cap_reg);
  assign wr_shift    = data_reg >> {iss_reg[1:0], 3'b000};
  assign wr_byte     = wr_shift[7:0];
  assign rd_cap_next = cap_reg + {2'b00, pipe2_reg};
  assign wr_cap_next = cap_reg + {2'b00, ram_wr_reg};

  // The byte arriving now lands in the lane selected by the capture counter.
  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_lane
      assign asm_next[8*gi +: 8] = (pipe2_reg && cap_reg == 3'(gi)) ? ram_din
                                                                    : asm_reg[8*gi +: 8];
    end
  endgenerate

`ifdef IO_FULL_WAIT_EN
  logic [1:0] io_sel;
  // In IDLE the candidate store is the incoming request's byte 0.
  assign io_sel   = (state_reg == IDLE) ? mem_address[17:16] : iss_addr[17:16];
  assign io_block = io_buffer_full && (io_sel == IO_HI);
`else
  logic unused_io;
  assign unused_io = io_buffer_full;
  assign io_block  = 1'b0;
`endif

  // Arbitration FSM, byte sequencing and all registered outputs.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state_reg    <= IDLE;
      addr_reg     <= '0;
      data_reg     <= '0;
      len_reg      <= '0;
      iss_reg      <= '0;
      cap_reg      <= '0;
      pipe1_reg    <= 1'b0;
      pipe2_reg    <= 1'b0;
      paused_reg   <= 1'b0;
      asm_reg      <= '0;
      ram_a_reg    <= '0;
      ram_dout_reg <= '0;
      ram_wr_reg   <= 1'b0;
      if_done_reg  <= 1'b0;
      if_out_reg   <= '0;
      mem_done_reg <= 1'b0;
      mem_out_reg  <= '0;
    end else begin
      paused_reg <= !rdy_in;
      if (rdy_in) begin
        if_done_reg  <= 1'b0;
        mem_done_reg <= 1'b0;
        case (state_reg)
          IDLE: begin
            ram_wr_reg <= 1'b0;
            // A done pulse blocks the grant so the finished requester can drop get.
            if (!if_done_reg && !mem_done_reg) begin
              if (mem_get) begin
                addr_reg  <= mem_address;
                data_reg  <= mem_data;
                len_reg   <= len_dec;
                cap_reg   <= 3'd0;
                asm_reg   <= '0;
                pipe2_reg <= 1'b0;
                if (mem_wr) begin
                  state_reg <= MEM_WR;
                  pipe1_reg <= 1'b0;
                  if (io_block) begin
                    iss_reg <= 3'd0;
                  end else begin
                    ram_a_reg    <= mem_address;
                    ram_dout_reg <= mem_data[7:0];
                    ram_wr_reg   <= 1'b1;
                    iss_reg      <= 3'd1;
                  end
                end else begin
                  state_reg <= MEM_RD;
                  ram_a_reg <= mem_address;
                  iss_reg   <= 3'd1;
                  pipe1_reg <= 1'b1;
                end
              end else if (if_pc_get && !if_flush) begin
                state_reg <= IF_RD;
                addr_reg  <= if_pc_address;
                len_reg   <= 3'd4;
                ram_a_reg <= if_pc_address;
                iss_reg   <= 3'd1;
                cap_reg   <= 3'd0;
                asm_reg   <= '0;
                pipe1_reg <= 1'b1;
                pipe2_reg <= 1'b0;
              end
            end
          end

          IF_RD, MEM_RD: begin
            if (state_reg == IF_RD && if_flush) begin
              // Abort the fetch; the RAM address is left where it was.
              state_reg <= IDLE;
              pipe1_reg <= 1'b0;
              pipe2_reg <= 1'b0;
            end else if (paused_reg) begin
              // Bytes in flight during the pause were dropped: re-address from
              // the first uncaptured byte.
              ram_a_reg <= cap_addr;
              iss_reg   <= cap_reg + 3'd1;
              pipe1_reg <= 1'b1;
              pipe2_reg <= 1'b0;
            end else begin
              pipe2_reg <= pipe1_reg;
              asm_reg   <= asm_next;
              cap_reg   <= rd_cap_next;
              if (iss_reg < len_reg) begin
                ram_a_reg <= iss_addr;
                iss_reg   <= iss_reg + 3'd1;
                pipe1_reg <= 1'b1;
              end else begin
                pipe1_reg <= 1'b0;
              end
              if (pipe2_reg && rd_cap_next == len_reg) begin
                state_reg <= IDLE;
                if (state_reg == IF_RD) begin
                  if_done_reg <= 1'b1;
                  if_out_reg  <= asm_next;
                end else begin
                  mem_done_reg <= 1'b1;
                  mem_out_reg  <= asm_next;
                end
              end
            end
          end

          MEM_WR: begin
            // A byte presented with ram_wr high is written at this edge.
            cap_reg <= wr_cap_next;
            if (iss_reg < len_reg) begin
              if (io_block) begin
                ram_wr_reg <= 1'b0;
              end else begin
                ram_a_reg    <= iss_addr;
                ram_dout_reg <= wr_byte;
                ram_wr_reg   <= 1'b1;
                iss_reg      <= iss_reg + 3'd1;
              end
            end else begin
              ram_wr_reg <= 1'b0;
              if (wr_cap_next == len_reg) begin
                mem_done_reg <= 1'b1;
                state_reg    <= IDLE;
              end
            end
          end

          default: state_reg <= IDLE;
        endcase
      end
    end
  end

  assign ram_a    = ram_a_reg;
  assign ram_dout = ram_dout_reg;
  assign ram_wr   = ram_wr_reg & rdy_in;
  assign if_done  = if_done_reg;
  assign if_out   = if_out_reg;
  assign mem_done = mem_done_reg;
  assign mem_out  = mem_out_reg;

endmodule

// File: tb/tb_ram_arbiter.sv
// tb_ram_arbiter: directed bench for ram_arbiter with a byte-wide RAM model.
// Build with IO_FULL_WAIT_EN defined to exercise the IO store wait.
module tb_ram_arbiter;

  logic        clk_in = 1'b0;
  logic        rst_in;
  logic        rdy_in;
  logic        io_buffer_full;
  logic [7:0]  ram_din;
  logic [7:0]  ram_dout;
  logic [31:0] ram_a;
  logic        ram_wr;
  logic        if_pc_get;
  logic [31:0] if_pc_address;
  logic        if_flush;
  logic        if_done;
  logic [31:0] if_out;
  logic        mem_get;
  logic        mem_wr;
  logic [31:0] mem_address;
  logic [31:0] mem_data;
  logic [2:0]  mem_len;
  logic        mem_done;
  logic [31:0] mem_out;

  int checks   = 0;
  int failures = 0;

  // Preload port into the RAM model, driven by the stimulus process.
  logic        pre_we;
  logic [17:0] pre_addr;
  logic [7:0]  pre_data;

  logic [7:0]  ram_mem [0:262143];

  always #5 clk_in = ~clk_in;

  ram_arbiter #(.ADDR_W(32), .IO_HI(2'b11)) dut (
    .clk_in         (clk_in),
    .rst_in         (rst_in),
    .rdy_in         (rdy_in),
    .io_buffer_full (io_buffer_full),
    .ram_din        (ram_din),
    .ram_dout       (ram_dout),
    .ram_a          (ram_a),
    .ram_wr         (ram_wr),
    .if_pc_get      (if_pc_get),
    .if_pc_address  (if_pc_address),
    .if_flush       (if_flush),
    .if_done        (if_done),
    .if_out         (if_out),
    .mem_get        (mem_get),
    .mem_wr         (mem_wr),
    .mem_address    (mem_address),
    .mem_data       (mem_data),
    .mem_len        (mem_len),
    .mem_done       (mem_done),
    .mem_out        (mem_out)
  );

  // RAM model: address sampled at an edge, data valid during the next cycle.
  always @(posedge clk_in) begin
    if (pre_we)
      ram_mem[pre_addr] <= pre_data;
    else if (ram_wr)
      ram_mem[ram_a[17:0]] <= ram_dout;
    ram_din <= ram_mem[ram_a[17:0]];
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  task automatic poke(input logic [17:0] a, input logic [7:0] d);
    pre_addr = a;
    pre_data = d;
    pre_we   = 1'b1;
    tick();
    pre_we   = 1'b0;
  endtask

  task automatic req_mem(input logic wr, input logic [31:0] a, input logic [31:0] d,
                         input logic [2:0] len);
    mem_get     = 1'b1;
    mem_wr      = wr;
    mem_address = a;
    mem_data    = d;
    mem_len     = len;
  endtask

  task automatic req_if(input logic [31:0] a);
    if_pc_get     = 1'b1;
    if_pc_address = a;
  endtask

  // Drop both requests and spend the turnaround cycle.
  task automatic release_all();
    mem_get   = 1'b0;
    if_pc_get = 1'b0;
    tick();
  endtask

  // Index (0 = first edge after the call) of the first done pulse, -1 on timeout.
  task automatic wait_done(input bit is_if, output int edges);
    edges = -1;
    for (int e = 0; e < 40; e++) begin
      tick();
      if ((is_if && if_done) || (!is_if && mem_done)) begin
        edges = e;
        break;
      end
    end
  endtask

  initial begin
    int edges;
    int seen;
    logic [31:0] word;

    rst_in = 1'b1; rdy_in = 1'b1; io_buffer_full = 1'b0;
    if_pc_get = 1'b0; if_pc_address = '0; if_flush = 1'b0;
    mem_get = 1'b0; mem_wr = 1'b0; mem_address = '0; mem_data = '0; mem_len = 3'd4;
    pre_we = 1'b0; pre_addr = '0; pre_data = '0;

    // Preload while held in reset.
    poke(18'h01000, 8'h13); poke(18'h01001, 8'h05); poke(18'h01002, 8'h00); poke(18'h01003, 8'h00);
    poke(18'h03002, 8'h34); poke(18'h03003, 8'h82);
    poke(18'h00040, 8'h93); poke(18'h00041, 8'h00); poke(18'h00042, 8'h10); poke(18'h00043, 8'h00);
    poke(18'h05000, 8'h11); poke(18'h05001, 8'h22); poke(18'h05002, 8'h33); poke(18'h05003, 8'h44);

    check("rst_ram_a",    ram_a,    32'h0);
    check("rst_ram_dout", {24'h0, ram_dout}, 32'h0);
    check("rst_ram_wr",   {31'h0, ram_wr},   32'h0);
    check("rst_if_done",  {31'h0, if_done},  32'h0);
    check("rst_if_out",   if_out,   32'h0);
    check("rst_mem_done", {31'h0, mem_done}, 32'h0);
    check("rst_mem_out",  mem_out,  32'h0);
    rst_in = 1'b0;
    tick();

    // IF fetch at 0x1000 with per-edge address checks.
    req_if(32'h1000);
    for (int e = 0; e <= 5; e++) begin
      tick();
      if (e <= 3) check($sformatf("if_a_e%0d", e), ram_a, 32'h1000 + 32'(e));
      check($sformatf("if_done_e%0d", e), {31'h0, if_done}, (e == 5) ? 32'h1 : 32'h0);
    end
    check("if_out_1000", if_out, 32'h00000513);
    $display("txn fetch addr=00001000 data=%h", if_out);
    release_all();

    // Store word while a fetch is also requested; MEM wins, then IF after turnaround.
    word = 32'hDEADBEEF;
    req_mem(1'b1, 32'h2000, word, 3'd4);
    req_if(32'h40);
    for (int e = 0; e <= 3; e++) begin
      tick();
      check($sformatf("sw_wr_e%0d", e), {31'h0, ram_wr}, 32'h1);
      check($sformatf("sw_a_e%0d", e), ram_a, 32'h2000 + 32'(e));
      check($sformatf("sw_d_e%0d", e), {24'h0, ram_dout}, (word >> (8 * e)) & 32'hFF);
    end
    tick();
    check("sw_done", {31'h0, mem_done}, 32'h1);
    check("sw_wr_off", {31'h0, ram_wr}, 32'h0);
    mem_get = 1'b0;
    tick();
    check("turnaround_a", ram_a, 32'h2003);
    tick();
    check("if_after_sw_a", ram_a, 32'h40);
    wait_done(1'b1, edges);
    check("if_after_sw_lat", 32'(edges), 32'd4);
    check("if_after_sw_out", if_out, 32'h00100093);
    check("sw_ram", {ram_mem[18'h2003], ram_mem[18'h2002], ram_mem[18'h2001], ram_mem[18'h2000]}, 32'hDEADBEEF);
    $display("txn store addr=00002000 data=deadbeef then fetch data=%h", if_out);
    release_all();

    // lh at 0x3002.
    req_mem(1'b0, 32'h3002, 32'h0, 3'd2);
    wait_done(1'b0, edges);
    check("lh_lat", 32'(edges), 32'd3);
    check("lh_out", mem_out, 32'h00008234);
    $display("txn load2 addr=00003002 data=%h", mem_out);
    release_all();

    // lb at 0x3003, zero-extended.
    req_mem(1'b0, 32'h3003, 32'h0, 3'd1);
    wait_done(1'b0, edges);
    check("lb_lat", 32'(edges), 32'd2);
    check("lb_out", mem_out, 32'h00000082);
    $display("txn load1 addr=00003003 data=%h", mem_out);
    release_all();

    // Illegal length 3 behaves as a word load.
    req_mem(1'b0, 32'h1000, 32'h0, 3'd3);
    wait_done(1'b0, edges);
    check("len3_lat", 32'(edges), 32'd5);
    check("len3_out", mem_out, 32'h00000513);
    $display("txn load3as4 addr=00001000 data=%h", mem_out);
    release_all();

    // Flush at E2 of a fetch, then a new fetch at 0x40.
    req_if(32'h1000);
    tick();
    tick();
    if_flush = 1'b1;
    tick();
    check("flush_a_hold", ram_a, 32'h1001);
    check("flush_no_done", {31'h0, if_done}, 32'h0);
    if_flush = 1'b0;
    if_pc_address = 32'h40;
    wait_done(1'b1, edges);
    check("flush_refetch_lat", 32'(edges), 32'd5);
    check("flush_refetch_out", if_out, 32'h00100093);
    $display("txn flushed fetch, refetch addr=00000040 data=%h", if_out);
    release_all();

    // rdy_in low at E2 of a word load.
    req_mem(1'b0, 32'h5000, 32'h0, 3'd4);
    tick();
    tick();
    rdy_in = 1'b0;
    tick();
    check("pause_wr", {31'h0, ram_wr}, 32'h0);
    check("pause_a_e2", ram_a, 32'h5001);
    tick();
    check("pause_a_e3", ram_a, 32'h5001);
    check("pause_no_done", {31'h0, mem_done}, 32'h0);
    rdy_in = 1'b1;
    tick();
    check("resume_a", ram_a, 32'h5000);
    wait_done(1'b0, edges);
    check("resume_lat", 32'(edges), 32'd4);
    check("resume_out", mem_out, 32'h44332211);
    $display("txn paused load4 addr=00005000 data=%h", mem_out);
    release_all();

    // rdy_in low while a store byte is presented gates ram_wr.
    req_mem(1'b1, 32'h6000, 32'h00000077, 3'd1);
    tick();
    check("sb_wr_on", {31'h0, ram_wr}, 32'h1);
    rdy_in = 1'b0;
    #1;
    check("sb_wr_gated", {31'h0, ram_wr}, 32'h0);
    tick();
    check("sb_pause_no_done", {31'h0, mem_done}, 32'h0);
    rdy_in = 1'b1;
    #1;
    check("sb_wr_resumed", {31'h0, ram_wr}, 32'h1);
    tick();
    check("sb_done", {31'h0, mem_done}, 32'h1);
    check("sb_ram", {24'h0, ram_mem[18'h6000]}, 32'h77);
    $display("txn paused store1 addr=00006000 data=77");
    release_all();

    // IO store with the uart buffer full.
    io_buffer_full = 1'b1;
    req_mem(1'b1, 32'h30000, 32'h00000041, 3'd1);
`ifdef IO_FULL_WAIT_EN
    for (int e = 0; e < 3; e++) begin
      tick();
      check($sformatf("io_wait_e%0d", e), {31'h0, ram_wr}, 32'h0);
    end
    io_buffer_full = 1'b0;
`endif
    tick();
    check("io_wr", {31'h0, ram_wr}, 32'h1);
    check("io_a", ram_a, 32'h30000);
    check("io_d", {24'h0, ram_dout}, 32'h41);
    tick();
    check("io_done", {31'h0, mem_done}, 32'h1);
    check("io_ram", {24'h0, ram_mem[18'h30000]}, 32'h41);
    $display("txn io store addr=00030000 data=41");
    io_buffer_full = 1'b0;
    release_all();

    // Asynchronous reset in the middle of a fetch.
    req_if(32'h1000);
    tick();
    tick();
    tick();
    #2;
    rst_in = 1'b1;
    #1;
    check("arst_ram_a",   ram_a,   32'h0);
    check("arst_ram_dout", {24'h0, ram_dout}, 32'h0);
    check("arst_if_out",  if_out,  32'h0);
    check("arst_mem_out", mem_out, 32'h0);
    if_pc_get = 1'b0;
    tick();
    tick();
    rst_in = 1'b0;
    seen = 0;
    for (int e = 0; e < 8; e++) begin
      tick();
      if (if_done) seen++;
    end
    check("arst_no_done", 32'(seen), 32'd0);
    req_if(32'h40);
    wait_done(1'b1, edges);
    check("arst_fetch_lat", 32'(edges), 32'd5);
    check("arst_fetch_out", if_out, 32'h00100093);
    $display("txn reset mid-fetch, refetch addr=00000040 data=%h", if_out);
    release_all();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
